// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - beam/sync inputs and pixel outputs of the pattern generator
//
// Purpose: bundles the sync-generator side signals and the DAC side signals
// of vga_pattern_gen so they travel as one port.
// Signals:
//   hsync_i, vsync_i  raw syncs from the sync generator (active-low)
//   display_on_i      beam in visible area
//   hpos_i, vpos_i    beam column / line
//   mode_i            pattern select, sampled once per frame
//   rgb_o             {R,G,B} 4 bits each
//   hsync_o, vsync_o  syncs re-timed to pixel latency
//   de_o              display enable re-timed to pixel latency
//   frame_o           one-cycle pulse after each box/mode update
// Modports: master drives the beam side and observes pixels, slave is the generator.

interface vga_pattern_gen_if;
  logic        hsync_i;
  logic        vsync_i;
  logic        display_on_i;
  logic [9:0]  hpos_i;
  logic [8:0]  vpos_i;
  logic [1:0]  mode_i;
  logic [11:0] rgb_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        frame_o;

  modport master (
    output hsync_i, vsync_i, display_on_i, hpos_i, vpos_i, mode_i,
    input  rgb_o, hsync_o, vsync_o, de_o, frame_o
  );

  modport slave (
    input  hsync_i, vsync_i, display_on_i, hpos_i, vpos_i, mode_i,
    output rgb_o, hsync_o, vsync_o, de_o, frame_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage VGA pixel pattern generator with bouncing box
//
// Purpose: turns raw beam position and syncs into 12-bit RGB pixels for one of
// four patterns (box, colour bars, checker with box, white). Box position and
// pattern are updated once per frame on the falling edge of vsync_i.
// Ports:
//   clk_i   pixel clock (shared with the sync generator)
//   rstn_i  asynchronous active-low reset
//   vif     slave side of vga_pattern_gen_if (beam inputs, pixel/sync outputs)

module vga_pattern_gen #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  vga_pattern_gen_if.slave  vif
);

  localparam logic [10:0] X_LIM  = 11'(H_DISPLAY - BOX_SIZE);
  localparam logic [9:0]  Y_LIM  = 10'(V_DISPLAY - BOX_SIZE);
  localparam logic [10:0] X_STEP = 11'(STEP);
  localparam logic [9:0]  Y_STEP = 10'(STEP);
  localparam logic [10:0] X_SIZE = 11'(BOX_SIZE);
  localparam logic [9:0]  Y_SIZE = 10'(BOX_SIZE);

  // frame event / box state
  logic       vsync_d;
  logic       run_q;
  logic       frame_evt;
  logic       frame_q;
  logic [1:0] mode_q;
  logic [9:0] box_x, box_x_nx;
  logic [8:0] box_y, box_y_nx;
  logic       dir_x, dir_x_nx;
  logic       dir_y, dir_y_nx;
  logic [10:0] x_fwd;
  logic [9:0]  y_fwd;

  // stage 1
  logic       in_box_c, in_box_q;
  logic [2:0] bar_c, bar_q;
  logic       checker_q;
  logic       de_q1, hs_q1, vs_q1;

  // stage 2
  logic [11:0] rgb_c, rgb_q;
  logic        de_q2, hs_q2, vs_q2;

  // run_q is low only on the first edge after reset release, so a vsync_i
  // that is already low at release (vsync_d resets high) is not taken as an edge.
  assign frame_evt = run_q & vsync_d & ~vif.vsync_i;

  always_comb begin
    x_fwd    = {1'b0, box_x} + X_STEP;
    y_fwd    = {1'b0, box_y} + Y_STEP;
    box_x_nx = box_x;
    box_y_nx = box_y;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    if (!dir_x) begin
      if (x_fwd >= X_LIM) begin
        box_x_nx = X_LIM[9:0];
        dir_x_nx = 1'b1;
      end else begin
        box_x_nx = x_fwd[9:0];
      end
    end else begin
      if ({1'b0, box_x} <= X_STEP) begin
        box_x_nx = '0;
        dir_x_nx = 1'b0;
      end else begin
        box_x_nx = box_x - X_STEP[9:0];
      end
    end
    if (!dir_y) begin
      if (y_fwd >= Y_LIM) begin
        box_y_nx = Y_LIM[8:0];
        dir_y_nx = 1'b1;
      end else begin
        box_y_nx = y_fwd[8:0];
      end
    end else begin
      if ({1'b0, box_y} <= Y_STEP) begin
        box_y_nx = '0;
        dir_y_nx = 1'b0;
      end else begin
        box_y_nx = box_y - Y_STEP[8:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsync_d <= 1'b1;
      run_q   <= 1'b0;
      frame_q <= 1'b0;
      mode_q  <= '0;
      box_x   <= '0;
      box_y   <= '0;
      dir_x   <= 1'b0;
      dir_y   <= 1'b0;
    end else begin
      vsync_d <= vif.vsync_i;
      run_q   <= 1'b1;
      frame_q <= frame_evt;
      if (frame_evt) begin
        mode_q <= vif.mode_i;
        box_x  <= box_x_nx;
        box_y  <= box_y_nx;
        dir_x  <= dir_x_nx;
        dir_y  <= dir_y_nx;
      end
    end
  end

  // bar index = hpos/80 clamped to 7, built from threshold compares
  always_comb begin
    bar_c = '0;
    for (int k = 1; k < 8; k++) begin
      if (vif.hpos_i >= 10'(80 * k)) bar_c = 3'(k);
    end
    in_box_c = ({1'b0, vif.hpos_i} >= {1'b0, box_x}) &&
               ({1'b0, vif.hpos_i} <  ({1'b0, box_x} + X_SIZE)) &&
               ({1'b0, vif.vpos_i} >= {1'b0, box_y}) &&
               ({1'b0, vif.vpos_i} <  ({1'b0, box_y} + Y_SIZE));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_box_q  <= 1'b0;
      bar_q     <= '0;
      checker_q <= 1'b0;
      de_q1     <= 1'b0;
      hs_q1     <= 1'b1;
      vs_q1     <= 1'b1;
    end else begin
      in_box_q  <= in_box_c;
      bar_q     <= bar_c;
      checker_q <= vif.hpos_i[5] ^ vif.vpos_i[5];
      de_q1     <= vif.display_on_i;
      hs_q1     <= vif.hsync_i;
      vs_q1     <= vif.vsync_i;
    end
  end

  always_comb begin
    rgb_c = 12'h000;
    case (mode_q)
      2'd0:    rgb_c = in_box_q ? 12'hF00 : 12'h000;
      2'd1:    rgb_c = {{4{bar_q[2]}}, {4{bar_q[1]}}, {4{bar_q[0]}}};
      2'd2:    rgb_c = in_box_q ? 12'h0F0 : (checker_q ? 12'h444 : 12'h000);
      default: rgb_c = 12'hFFF;
    endcase
    if (!de_q1) rgb_c = 12'h000;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_q <= '0;
      de_q2 <= 1'b0;
      hs_q2 <= 1'b1;
      vs_q2 <= 1'b1;
    end else begin
      rgb_q <= rgb_c;
      de_q2 <= de_q1;
      hs_q2 <= hs_q1;
      vs_q2 <= vs_q1;
    end
  end

  assign vif.rgb_o   = rgb_q;
  assign vif.de_o    = de_q2;
  assign vif.hsync_o = hs_q2;
  assign vif.vsync_o = vs_q2;
  assign vif.frame_o = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen

module tb_vga_pattern_gen;
  localparam int H   = 640;
  localparam int V   = 480;
  localparam int BOX = 32;
  localparam int STP = 2;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_gen_if vif();

  vga_pattern_gen #(.H_DISPLAY(H), .V_DISPLAY(V), .BOX_SIZE(BOX), .STEP(STP)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .vif   (vif.slave)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  typedef struct {
    logic [9:0]  h;
    logic [8:0]  v;
    logic        d;
    logic [11:0] rgb;
  } vec_t;

  // mode 0, box at (2,2)
  vec_t t_box[7] = '{
    '{10'd2,   9'd2,  1'b1, 12'hF00}, '{10'd33, 9'd33, 1'b1, 12'hF00},
    '{10'd34,  9'd2,  1'b1, 12'h000}, '{10'd1,  9'd2,  1'b1, 12'h000},
    '{10'd2,   9'd34, 1'b1, 12'h000}, '{10'd33, 9'd1,  1'b1, 12'h000},
    '{10'd10,  9'd10, 1'b0, 12'h000}};
  // mode_i already 1, mode_q still 0, box at (2,2)
  vec_t t_latch[4] = '{
    '{10'd0,   9'd200, 1'b1, 12'h000}, '{10'd80, 9'd200, 1'b1, 12'h000},
    '{10'd560, 9'd200, 1'b1, 12'h000}, '{10'd10, 9'd10,  1'b1, 12'hF00}};
  // mode 1 bars
  vec_t t_bars[11] = '{
    '{10'd0,   9'd200, 1'b1, 12'h000}, '{10'd79,  9'd200, 1'b1, 12'h000},
    '{10'd80,  9'd200, 1'b1, 12'h00F}, '{10'd160, 9'd200, 1'b1, 12'h0F0},
    '{10'd240, 9'd200, 1'b1, 12'h0FF}, '{10'd320, 9'd200, 1'b1, 12'hF00},
    '{10'd400, 9'd200, 1'b1, 12'hF0F}, '{10'd480, 9'd200, 1'b1, 12'hFF0},
    '{10'd560, 9'd200, 1'b1, 12'hFFF}, '{10'd639, 9'd200, 1'b1, 12'hFFF},
    '{10'd560, 9'd200, 1'b0, 12'h000}};
  // mode 2, box at (6,6)
  vec_t t_chk[8] = '{
    '{10'd6,   9'd6,  1'b1, 12'h0F0}, '{10'd37, 9'd37, 1'b1, 12'h0F0},
    '{10'd38,  9'd6,  1'b1, 12'h444}, '{10'd100, 9'd10, 1'b1, 12'h444},
    '{10'd64,  9'd64, 1'b1, 12'h000}, '{10'd40, 9'd40, 1'b1, 12'h000},
    '{10'd5,   9'd6,  1'b1, 12'h000}, '{10'd6,  9'd6,  1'b0, 12'h000}};
  // mode 0, box at (608,288)
  vec_t t_edge[5] = '{
    '{10'd608, 9'd288, 1'b1, 12'hF00}, '{10'd607, 9'd288, 1'b1, 12'h000},
    '{10'd639, 9'd319, 1'b1, 12'hF00}, '{10'd639, 9'd320, 1'b1, 12'h000},
    '{10'd620, 9'd287, 1'b1, 12'h000}};

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  bit   in_reset = 1'b1;

  // reference model state
  bit       run_m, vs_prev_m, ev_prev;
  int       bx, by, ev_cnt;
  bit       dxm, dym;
  logic [1:0] mode_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic d);
    int b;
    bit inb, cb;
    logic [2:0] b3;
    if (!d) return 12'h000;
    b = h / 80;
    if (b > 7) b = 7;
    b3  = 3'(b);
    inb = (h >= bx) && (h < bx + BOX) && (v >= by) && (v < by + BOX);
    cb  = ((h / 32) % 2) != ((v / 32) % 2);
    case (mode_m)
      2'd0:    return inb ? 12'hF00 : 12'h000;
      2'd1:    return {{4{b3[2]}}, {4{b3[1]}}, {4{b3[0]}}};
      2'd2:    return inb ? 12'h0F0 : (cb ? 12'h444 : 12'h000);
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic model_event(input logic [1:0] m);
    ev_cnt++;
    mode_m = m;
    if (!dxm) begin
      if (bx + STP >= H - BOX) begin bx = H - BOX; dxm = 1'b1; end
      else bx = bx + STP;
    end else begin
      if (bx <= STP) begin bx = 0; dxm = 1'b0; end
      else bx = bx - STP;
    end
    if (!dym) begin
      if (by + STP >= V - BOX) begin by = V - BOX; dym = 1'b1; end
      else by = by + STP;
    end else begin
      if (by <= STP) begin by = 0; dym = 1'b0; end
      else by = by - STP;
    end
  endtask

  task automatic model_reset();
    bx = 0; by = 0; dxm = 1'b0; dym = 1'b0; mode_m = 2'd0; ev_cnt = 0;
    run_m = 1'b0; vs_prev_m = 1'b1; ev_prev = 1'b0;
  endtask

  task automatic apply(input logic [9:0] h, input logic [8:0] v, input logic d,
                       input logic hs, input logic vs, input logic [1:0] m,
                       input bit use_exp, input logic [11:0] rgb_exp);
    exp_t e, o;
    bit   ev;
    if (in_reset) begin
      chk("rst_rgb", vif.rgb_o, 12'h000);
      chk("rst_hsync", vif.hsync_o, 1'b1);
      chk("rst_vsync", vif.vsync_o, 1'b1);
      chk("rst_de", vif.de_o, 1'b0);
      chk("rst_frame", vif.frame_o, 1'b0);
    end else begin
      chk("frame_o", vif.frame_o, ev_prev);
    end
    vif.hpos_i = h; vif.vpos_i = v; vif.display_on_i = d;
    vif.hsync_i = hs; vif.vsync_i = vs; vif.mode_i = m;
    if (!in_reset) begin
      e.rgb = use_exp ? rgb_exp : model_rgb(int'(h), int'(v), d);
      e.hs = hs; e.vs = vs; e.de = d;
      sb.push_back(e);
      if (sb.size() >= 3) begin
        o = sb.pop_front();
        chk("rgb_o", vif.rgb_o, o.rgb);
        chk("hsync_o", vif.hsync_o, o.hs);
        chk("vsync_o", vif.vsync_o, o.vs);
        chk("de_o", vif.de_o, o.de);
      end
      ev = run_m && vs_prev_m && !vs;
      run_m = 1'b1;
      vs_prev_m = vs;
      ev_prev = ev;
      if (ev) model_event(m);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [8:0] v, input logic d,
                       input logic hs, input logic vs, input logic [1:0] m,
                       input bit use_exp, input logic [11:0] rgb_exp);
    @(posedge clk); #1;
    apply(h, v, d, hs, vs, m, use_exp, rgb_exp);
  endtask

  task automatic do_assert();
    @(posedge clk); #1;
    rstn = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("async_rst_rgb", vif.rgb_o, 12'h000);
    chk("async_rst_hsync", vif.hsync_o, 1'b1);
    chk("async_rst_de", vif.de_o, 1'b0);
  endtask

  task automatic do_release(input logic [9:0] h, input logic [8:0] v, input logic d,
                            input logic hs, input logic vs, input logic [1:0] m);
    exp_t r;
    @(posedge clk); #1;
    rstn = 1'b1;
    in_reset = 1'b0;
    model_reset();
    sb.delete();
    r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0;
    sb.push_back(r);
    sb.push_back(r);
    apply(h, v, d, hs, vs, m, 1'b0, 12'h000);
  endtask

  task automatic frame(input logic [1:0] m);
    drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, m, 1'b0, 12'h000);
    drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b0, m, 1'b0, 12'h000);
    drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b0, m, 1'b0, 12'h000);
  endtask

  task automatic run_table(input vec_t t[], input logic [1:0] m);
    for (int i = 0; i < t.size(); i++)
      drive(t[i].h, t[i].v, t[i].d, 1'b1, 1'b1, m, 1'b1, t[i].rgb);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    vif.hpos_i = 10'd300; vif.vpos_i = 9'd100; vif.display_on_i = 1'b1;
    vif.hsync_i = 1'b1; vif.vsync_i = 1'b0; vif.mode_i = 2'd3;
    #2 rstn = 1'b0;

    // reset held mid-line, released while vsync_i is low: no event expected
    repeat (3) drive(10'd300, 9'd100, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 12'h000);
    do_release(10'd300, 9'd100, 1'b1, 1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 4; i++)
      drive(10'(301 + i), 9'd100, 1'(i % 2), 1'b1, 1'b0, 2'd3, 1'b0, 12'h000);

    // mode 3: latency and alignment of rgb/de/hsync
    frame(2'd3);
    for (int i = 0; i < 16; i++)
      drive(10'(i * 7), 9'd300, 1'((i % 5) < 3), 1'(!(i >= 6 && i < 9)), 1'b1, 2'd3, 1'b0, 12'h000);
    repeat (3) drive(10'd100, 9'd300, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 12'h000);

    // reset mid-frame while white pixels are on the output
    do_assert();
    repeat (2) drive(10'd100, 9'd300, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 12'h000);
    do_release(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    repeat (2) drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 12'h000);

    // frame 1: mode 0, box at (2,2)
    frame(2'd0);
    chk("box_x_ev1", dut.box_x, 10'd2);
    chk("box_y_ev1", dut.box_y, 9'd2);
    run_table(t_box, 2'd0);

    // mode_i changes mid-frame; output must stay mode 0 until the next event
    run_table(t_latch, 2'd1);
    frame(2'd1);
    run_table(t_bars, 2'd1);
    frame(2'd2);
    run_table(t_chk, 2'd2);

    // bounce run up to event 305
    for (int i = 0; i < 400 && ev_cnt < 305; i++) begin
      frame(2'd0);
      if (ev_cnt == 224) begin
        chk("box_y_ev224", dut.box_y, 9'd448);
        chk("dir_y_ev224", dut.dir_y, 1'b1);
      end
      if (ev_cnt == 225) chk("box_y_ev225", dut.box_y, 9'd446);
      if (ev_cnt == 304) begin
        chk("box_x_ev304", dut.box_x, 10'd608);
        chk("dir_x_ev304", dut.dir_x, 1'b1);
        chk("box_y_ev304", dut.box_y, 9'd288);
        run_table(t_edge, 2'd0);
      end
      if (ev_cnt == 305) begin
        chk("box_x_ev305", dut.box_x, 10'd606);
        chk("dir_x_ev305", dut.dir_x, 1'b1);
      end
    end
    repeat (3) drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-generation stage placed directly downstream of the 640x480 horizontal/vertical sync generator. It consumes raw beam position, display-enable and sync signals, and produces 12-bit RGB pixels. It can render four patterns, including a box that bounces around the screen and moves once per frame. Outputs go straight to the VGA DAC/pins, with syncs re-timed to match the pixel pipeline latency.

## Interface
Parameters:
- H_DISPLAY, 640, visible width in pixels
- V_DISPLAY, 480, visible height in lines
- BOX_SIZE, 32, box edge length in pixels; must be ≥1 and < V_DISPLAY
- STEP, 2, box displacement per frame on each axis; must be ≥1 and < V_DISPLAY-BOX_SIZE

Ports:
- clk_i  in  1  pixel clock; same clock as the sync generator
- rstn_i  in  1  reset; asynchronous, active-low
- hsync_i  in  1  horizontal sync from the sync generator, active-low
- vsync_i  in  1  vertical sync from the sync generator, active-low
- display_on_i  in  1  high while the beam is in the visible area
- hpos_i  in  10  beam column
- vpos_i  in  9  beam line
- mode_i  in  2  pattern select, quasi-static
- rgb_o  out  12  pixel colour as {R[3:0],G[3:0],B[3:0]}
- hsync_o  out  1  hsync_i delayed 2 cycles
- vsync_o  out  1  vsync_i delayed 2 cycles
- de_o  out  1  display_on_i delayed 2 cycles
- frame_o  out  1  one-cycle pulse on each box/mode update

## Operation
- **Frame event:** `vsync_d` holds vsync_i registered. The event is `vsync_d & ~vsync_i`, i.e. the falling edge of vsync_i. On the event cycle:
  - mode_i is latched into mode_q.
  - The box position updates.
  - frame_o pulses on the following cycle.
- **Box state:** box_x (10 bit) and box_y (9 bit) give the top-left corner. dir_x=0 means right; dir_y=0 means down.
- **Move rule, x axis (y is analogous, using V_DISPLAY):**
  - Moving right: if box_x+STEP ≥ H_DISPLAY-BOX_SIZE, set box_x=H_DISPLAY-BOX_SIZE and dir_x=1. Otherwise box_x+=STEP.
  - Moving left: if box_x ≤ STEP, set box_x=0 and dir_x=0. Otherwise box_x-=STEP.
  - Compute sums at 11/10 bits so no wrap is possible.
  - Both axes update in the same event, independently. A corner hit flips both directions.
- **Stage 1 (registered):**
  - in_box = hpos_i ≥ box_x && hpos_i < box_x+BOX_SIZE && vpos_i ≥ box_y && vpos_i < box_y+BOX_SIZE.
  - bar = hpos_i/80, clamped to 0..7 and computed with comparators, not a divider.
  - checker = hpos_i[5]^vpos_i[5].
  - display_on_i, hsync_i and vsync_i are also registered.
- **Stage 2 colour selection (registered), by mode_q:**
  - 0: in_box ? 12'hF00 : 12'h000
  - 1: bars; each channel = {4{bit}} with R=bar[2], G=bar[1], B=bar[0]
  - 2: in_box ? 12'h0F0 : (checker ? 12'h444 : 12'h000)
  - 3: 12'hFFF
- **Blanking:** when the stage-1 display flag is 0, rgb_o = 12'h000 regardless of mode.

## Timing
- Latency is exactly 2 clk_i cycles from inputs to rgb_o, de_o, hsync_o and vsync_o. All four stay mutually aligned.
- Reset values (asynchronous, while rstn_i=0):
  - rgb_o=0, de_o=0, hsync_o=1, vsync_o=1, frame_o=0.
  - box_x=0, box_y=0, dir_x=0, dir_y=0.
  - mode_q=0 and vsync_d=1.
- After rstn_i rises, the first frame event needs a real high→low transition on vsync_i. If vsync_i is already low at release, no event occurs.
- Reset mid-frame: all state clears immediately. Pipeline contents are discarded. Outputs show reset values until 2 cycles after release.
- mode_i changes between events are ignored until the next event, so the pattern never changes mid-frame.
- The box is drawn with the position that was valid at the event and stays constant for the whole visible frame, which is tear-free.
- A frame event on the same cycle as rstn_i deassertion is not taken.

## Test plan
- **Reset:** hold rstn_i=0 mid-line, then release. Required: rgb_o=0, hsync_o=vsync_o=1, de_o=0; after 2 cycles the outputs track the inputs delayed by 2.
- **Latency/alignment:** mode 3 with display_on_i toggled. Required: rgb_o=12'hFFF exactly while de_o=1, 2 cycles after display_on_i; otherwise 0. hsync_o edges land 2 cycles after hsync_i edges.
- **Box render:** mode 0 after reset, at frame 1 (box_x=2, box_y=2). Required: pixel (2,2) = F00; pixels (33,33) = F00; (34,2) = 000; (1,2) = 000.
- **Right-edge bounce:** 304 frame events. Required: box_x reaches 608 at event 304 with dir_x=1; event 305 gives box_x=606. Meanwhile box_y hits 448 at event 224, then decreases.
- **Mode latching:** change mode_i 0→1 mid-frame. Required: rgb_o unchanged until after the next vsync_i falling edge. In the next frame, pixel hpos=0 = 000, hpos=80 = 00F, hpos=560 = FFF.
- **frame_o:** over 3 frames, exactly one 1-cycle pulse per vsync_i falling edge, one cycle after the edge. No pulse when vsync_i is low at reset release.
